// File: rtl/cordic_seq.sv
// Iteration sequencer for the single-step cordic datapath: accepts (x, y), drives
// ITER micro-rotations with k and atan(2^-k) constants, returns the final pair.
module cordic_seq #(
  parameter int WIDTH   = 33,
  parameter int ITER    = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  output logic             start_ready_o,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] dp_x_o,
  output logic [WIDTH-1:0] dp_y_o,
  output logic [WIDTH-1:0] dp_k_o,
  output logic [WIDTH-1:0] dp_e_k_o,
  output logic             dp_ce_o,
  input  logic             dp_done_i,
  input  logic [WIDTH-1:0] dp_n_out_i,
  input  logic [WIDTH-1:0] dp_y_out_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic             busy_o,
  output logic             err_o
);

  // state  | meaning
  // IDLE   | waiting for start, start_ready high
  // ISSUE  | one-cycle dp_ce strobe, watchdog cleared
  // WAIT   | waiting for dp_done, watchdog counting
  // OUT    | result held until res_ready
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [4:0]      K_LAST  = 5'(ITER - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] xr_q, xr_d, yr_q, yr_d;
  logic [4:0]       k_q, k_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             err_q, err_d;
  logic [31:0]      e_k_q, e_k_d;

  // round(atan(2^-k) * 2^30); from k=10 on the cubic term is below half an LSB
  function automatic logic [31:0] atan_rom(input logic [4:0] k);
    case (k)
      5'd0:    atan_rom = 32'h3243F6A9;
      5'd1:    atan_rom = 32'h1DAC6705;
      5'd2:    atan_rom = 32'h0FADBAFD;
      5'd3:    atan_rom = 32'h07F56EA7;
      5'd4:    atan_rom = 32'h03FEAB77;
      5'd5:    atan_rom = 32'h01FFD55C;
      5'd6:    atan_rom = 32'h00FFFAAB;
      5'd7:    atan_rom = 32'h007FFF55;
      5'd8:    atan_rom = 32'h003FFFEB;
      5'd9:    atan_rom = 32'h001FFFFD;
      5'd31:   atan_rom = 32'h00000000;
      default: atan_rom = 32'h40000000 >> k;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    k_d     = k_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          xr_d    = x_i;
          yr_d    = y_i;
          k_d     = 5'd0;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dp_done_i) begin
          xr_d = dp_n_out_i;
          yr_d = dp_y_out_i;
          if (k_q == K_LAST) begin
            state_d = S_OUT;
          end else begin
            k_d     = k_q + 5'd1;
            state_d = S_ISSUE;
          end
        end else if (wdog_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_OUT: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    e_k_d = atan_rom(k_d);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      k_q     <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      e_k_q   <= 32'h3243F6A9;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      k_q     <= k_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      e_k_q   <= e_k_d;
    end
  end

  assign start_ready_o = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign dp_ce_o       = (state_q == S_ISSUE);
  assign res_valid_o   = (state_q == S_OUT);
  assign err_o         = err_q;
  assign dp_x_o        = xr_q;
  assign dp_y_o        = yr_q;
  assign dp_k_o        = {{(WIDTH-5){1'b0}}, k_q};
  assign dp_e_k_o      = {{(WIDTH-32){1'b0}}, e_k_q};
  assign x_o           = xr_q;
  assign y_o           = yr_q;

endmodule

// File: tb/tb_cordic_seq.sv
// Directed bench for cordic_seq with a behavioural datapath stub (n = x+1, y = y+2).
module tb_cordic_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_ready;
  logic [32:0] x_in, y_in;
  logic [32:0] dp_x, dp_y, dp_k, dp_e_k;
  logic        dp_ce, dp_done;
  logic [32:0] dp_n_out, dp_y_out;
  logic        res_valid, res_ready;
  logic [32:0] x_out, y_out;
  logic        busy, err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cordic_seq #(.WIDTH(33), .ITER(16), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .start_i(start), .start_ready_o(start_ready),
    .x_i(x_in), .y_i(y_in),
    .dp_x_o(dp_x), .dp_y_o(dp_y), .dp_k_o(dp_k), .dp_e_k_o(dp_e_k),
    .dp_ce_o(dp_ce), .dp_done_i(dp_done),
    .dp_n_out_i(dp_n_out), .dp_y_out_i(dp_y_out),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .x_o(x_out), .y_o(y_out),
    .busy_o(busy), .err_o(err)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // datapath stub: done stub_delay cycles after CE, optional pulse during ISSUE
  int   stub_cnt;
  int   stub_delay;
  logic stub_never, stub_early;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     stub_cnt <= 0;
    else if (dp_ce && !stub_never)  stub_cnt <= stub_delay;
    else if (stub_cnt > 0)          stub_cnt <= stub_cnt - 1;
  end

  assign dp_done  = (stub_cnt == 1) || (stub_early && dp_ce);
  assign dp_n_out = dp_x + 33'd1;
  assign dp_y_out = dp_y + 33'd2;

  logic [31:0] rom_tb [16];
  int          ce_total = 0;
  int          op_base;
  logic [32:0] op_x, op_y;

  // every strobe: step index, constant and fed-back operands must follow the op
  always @(negedge clk) begin
    if (rst_n && dp_ce) begin
      automatic int s = ce_total - op_base;
      chk("step_k", dp_k, 64'(s));
      chk("step_ek", dp_e_k, (s >= 0 && s < 16) ? {32'd0, rom_tb[s]} : 64'hdead);
      chk("step_x", dp_x, 64'(op_x + 33'(s)));
      chk("step_y", dp_y, 64'(op_y + 33'(2 * s)));
      ce_total++;
    end
  end

  task automatic accept(input logic [32:0] x, input logic [32:0] y);
    @(negedge clk);
    op_x = x; op_y = y; op_base = ce_total;
    x_in = x; y_in = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ce_after_accept", dp_ce, 1);
    chk("err_cleared", err, 0);
  endtask

  task automatic run_op(input string tag, input logic [32:0] x, input logic [32:0] y,
                        input int hold, input int exp_lat, input int poke_k);
    int n;
    res_ready = (hold == 0);
    accept(x, y);
    n = 0;
    while (!res_valid && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (poke_k >= 0 && dp_ce && dp_k == 33'(poke_k)) begin
        start = 1'b1; x_in = 33'd100; y_in = 33'd200;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_x_out"}, x_out, x + 33'd16);
    chk({tag, "_y_out"}, y_out, y + 33'd32);
    chk({tag, "_steps"}, ce_total - op_base, 16);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, res_valid, 1);
      chk({tag, "_hold_x"}, x_out, x + 33'd16);
      chk({tag, "_hold_y"}, y_out, y + 33'd32);
    end
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_consumed"}, res_valid, 0);
    chk({tag, "_ready_again"}, start_ready, 1);
  endtask

  initial begin
    int n;
    int seen_valid;
    int ce_snap;
    rom_tb = '{32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
               32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
               32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
               32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000};
    op_base = 0; op_x = '0; op_y = '0;
    stub_delay = 1; stub_never = 1'b0; stub_early = 1'b0;

    // reset with garbage on the inputs
    rst_n = 1'b0;
    start = 1'b1; res_ready = 1'b1;
    x_in = 33'($urandom); y_in = 33'($urandom);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_dp_ce", dp_ce, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_dp_x", dp_x, 0);
    chk("rst_dp_y", dp_y, 0);
    chk("rst_dp_k", dp_k, 0);
    chk("rst_dp_e_k", dp_e_k, 64'h3243F6A9);
    chk("rst_x_out", x_out, 0);
    chk("rst_y_out", y_out, 0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("nominal", 33'd5, 33'd10, 0, 32, -1);
    run_op("backpressure", 33'd5, 33'd10, 5, 32, -1);

    stub_delay = 7; stub_early = 1'b1;
    run_op("slow_early", 33'd5, 33'd10, 0, 128, -1);
    stub_delay = 1; stub_early = 1'b0;

    // watchdog: datapath never answers
    stub_never = 1'b1;
    accept(33'd5, 33'd10);
    n = 0;
    while (!err && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_edges", n, 65);
    chk("timeout_busy", busy, 0);
    chk("timeout_ready", start_ready, 1);
    chk("timeout_steps", ce_total - op_base, 1);
    stub_never = 1'b0;
    run_op("after_timeout", 33'd7, 33'd3, 0, 32, -1);
    chk("err_stays_clear", err, 0);

    run_op("start_busy", 33'd5, 33'd10, 0, 32, 3);

    // reset in the middle of step 9
    res_ready = 1'b1;
    accept(33'd5, 33'd10);
    n = 0;
    while (!(dp_ce && dp_k == 33'd9) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_step9", dp_k, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_dp_ce", dp_ce, 0);
    chk("midrst_dp_k", dp_k, 0);
    chk("midrst_dp_x", dp_x, 0);
    chk("midrst_dp_e_k", dp_e_k, 64'h3243F6A9);
    chk("midrst_ready", start_ready, 1);
    ce_snap = ce_total;
    @(negedge clk); rst_n = 1'b1;
    seen_valid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (res_valid) seen_valid++;
    end
    chk("midrst_no_valid", seen_valid, 0);
    chk("midrst_no_ce", ce_total - ce_snap, 0);
    run_op("after_reset", 33'd1, 33'd2, 0, 32, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_seq.md
# cordic_seq

Iteration sequencer for the `cordic` single-step datapath. It accepts an operand pair (x, y) over a valid/ready handshake and drives the datapath for ITER micro-rotations. On each rotation it supplies the step index k and the matching e_k constant from an internal ROM, and feeds `n_out`/`y_out` back as the next x/y. It returns the final pair over a second valid/ready handshake. A per-step watchdog aborts with an error flag if the datapath never raises `done`.

## Interface
- WIDTH, 33, datapath word width (all data ports)
- ITER, 16, rotations per operation (1..32)
- TIMEOUT, 64, max cycles waited for dp_done per step (≥2)

- CLK  in  1  rising-edge clock; one clock domain
- RST_N  in  1  reset, asynchronous, active-low
- start  in  1  request valid
- start_ready  out  1  high only in IDLE
- x_in, y_in  in  WIDTH  operands, sampled on accept
- dp_x, dp_y  out  WIDTH  current x/y to datapath `x_in`/`y_in`
- dp_k  out  WIDTH  step index k, zero-extended, to datapath `k_in`
- dp_e_k  out  WIDTH  ROM[k] to datapath `e_k_in`
- dp_ce  out  1  one-cycle step strobe to datapath `CE`
- dp_done  in  1  datapath step complete
- dp_n_out, dp_y_out  in  WIDTH  datapath results
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- x_out, y_out  out  WIDTH  final pair
- busy  out  1  state ≠ IDLE
- err  out  1  sticky timeout flag; cleared on the next accepted start

## Operation
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE: start_ready=1. If start=1: latch x_in→xr, y_in→yr, k←0, err←0, go to ISSUE.
- ISSUE: dp_ce=1 for exactly one cycle, wdog←0, go to WAIT.
- WAIT: dp_ce=0, wdog increments each cycle.
  - If dp_done=1: xr←dp_n_out, yr←dp_y_out. If k=ITER-1, go to OUT; otherwise k←k+1 and go to ISSUE.
  - Else if wdog=TIMEOUT-1: err←1, go to IDLE. xr/yr keep the partial values.
- OUT: res_valid=1, x_out=xr, y_out=yr. If res_ready=1, go to IDLE.
- dp_x=xr, dp_y=yr, dp_k={0,k}, dp_e_k=ROM[k] are registered and stable from ISSUE through WAIT.
- ROM[k] = round(atan(2^-k)·2^30), two's complement, zero-extended to WIDTH. ROM[0]=0x3243F6A9.
- dp_done is ignored outside WAIT, including in the ISSUE cycle.
- start is ignored while busy=1. There is no queuing.
- Counter widths: k is 5 bits; wdog is clog2(TIMEOUT) bits. Both saturate-free within their ranges.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, start_ready=1.
  - dp_ce, res_valid, busy, err = 0.
  - xr, yr, k, wdog, dp_x, dp_y, dp_k = 0.
  - dp_e_k=ROM[0]; x_out, y_out = 0.
- Accept edge = the rising CLK edge with start=1 in IDLE. dp_ce is high for the cycle following that edge.
- Each step takes 2 cycles minimum: ISSUE plus at least one WAIT cycle.
- With dp_done high on the first WAIT cycle, res_valid rises 2·ITER edges after the accept edge (32 for ITER=16).
- res_valid, x_out and y_out hold stable until the res_ready handshake. The next start can be accepted on the edge after that handshake, since start_ready=1 once the block is back in IDLE.
- Timeout: err and the return to IDLE occur TIMEOUT edges after the ISSUE→WAIT edge.
- RST_N low mid-operation: immediate return to reset values. No result is emitted and no dp_ce is produced until a new start.

## Test plan
- Reset: hold RST_N=0 with random inputs → all outputs at the reset values above, with dp_e_k=0x3243F6A9.
- Nominal run (ITER=16): datapath stub raises done 1 cycle after CE and returns n_out=x+1, y_out=y+2. Drive x_in=5, y_in=10 → x_out=21, y_out=42; dp_k steps 0..15 with one dp_ce per step; res_valid at edge 32.
- Backpressure: same run with res_ready low for 5 cycles after res_valid → res_valid and outputs stable for 5 cycles. Consumed on the 6th; start_ready=1 on the next cycle.
- Slow or early done: stub delays done 7 cycles per step and also pulses done during ISSUE → the early pulse is ignored; exactly 16 steps; latency 16·8=128 edges.
- Timeout (TIMEOUT=64): stub never raises done → err=1 and back in IDLE 64 edges after the first ISSUE. A following start clears err and the run completes normally.
- Reset and start while busy: pulse start at step 3 → ignored, no k disturbance. Assert RST_N=0 at step 9 → immediate reset values; no res_valid afterwards.
